// File: rtl/code_loader.sv
// Serial code loader: receives 8N1 UART bytes, assembles little-endian words into code memory
// and holds the CPU in reset until a full image with a matching checksum has been written.
`timescale 1ns/1ps
module code_loader #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          CODE_WORDS   = 8,
    parameter int          ADDR_WIDTH   = $clog2(CODE_WORDS),
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_nreset,
    output logic                  loading,
    output logic                  load_error
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [8:0]       MAX_N     = 9'(CODE_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_SYNC, GET_COUNT, GET_DATA, GET_CSUM, DONE, ERROR} ld_state_t;

    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             byte_valid, frame_err;

    ld_state_t         ld_state, ld_next;
    logic [7:0]        count, csum;
    logic [1:0]        byte_idx;
    logic [ADDR_WIDTH:0] word_idx;
    logic [23:0]       word_buf;
    logic              last_word;

    // ---------------- UART receiver ----------------
    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (clk_cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (clk_cnt == BIT_LAST && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    rx_next    = RX_IDLE;
                    byte_valid = rx_sync;
                    frame_err  = !rx_sync;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_next;
            // Counter restarts on each half-bit/bit boundary so samples land mid-bit.
            if (rx_state == RX_IDLE || clk_cnt == BIT_LAST ||
                (rx_state == RX_START && clk_cnt == HALF_LAST))
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + 1'b1;
            if (rx_state == RX_START)
                bit_cnt <= '0;
            if (rx_state == RX_DATA && clk_cnt == BIT_LAST) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // ---------------- Loader ----------------
    assign last_word = ({1'b0, count} == 9'(word_idx + 1'b1));

    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            WAIT_SYNC, DONE, ERROR:
                if (byte_valid && shift == SYNC_BYTE) ld_next = GET_COUNT;
            GET_COUNT: begin
                if (frame_err)
                    ld_next = ERROR;
                else if (byte_valid)
                    ld_next = (shift == 8'd0 || {1'b0, shift} > MAX_N) ? ERROR : GET_DATA;
            end
            GET_DATA: begin
                if (frame_err)
                    ld_next = ERROR;
                else if (byte_valid && byte_idx == 2'd3 && last_word)
                    ld_next = GET_CSUM;
            end
            GET_CSUM: begin
                if (frame_err)
                    ld_next = ERROR;
                else if (byte_valid)
                    ld_next = (shift == csum) ? DONE : ERROR;
            end
            default: ld_next = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state   <= WAIT_SYNC;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_error <= 1'b0;
            count      <= '0;
            csum       <= '0;
            byte_idx   <= '0;
            word_idx   <= '0;
            word_buf   <= '0;
        end else begin
            ld_state <= ld_next;
            mem_we   <= 1'b0;
            if (ld_next == ERROR && ld_state != ERROR)
                load_error <= 1'b1;
            if (byte_valid) begin
                case (ld_state)
                    WAIT_SYNC, DONE, ERROR: begin
                        if (shift == SYNC_BYTE) begin
                            load_error <= 1'b0;
                            csum       <= '0;
                            byte_idx   <= '0;
                            word_idx   <= '0;
                        end
                    end
                    GET_COUNT: count <= shift;
                    GET_DATA: begin
                        csum     <= csum + shift;
                        byte_idx <= byte_idx + 1'b1;
                        // Only three bytes are buffered; the fourth goes straight to the write.
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx[ADDR_WIDTH-1:0];
                            mem_wdata <= {shift, word_buf};
                            word_idx  <= word_idx + 1'b1;
                        end else begin
                            word_buf <= {shift, word_buf[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign loading    = (ld_state == GET_COUNT) || (ld_state == GET_DATA) || (ld_state == GET_CSUM);
    assign cpu_nreset = (ld_state == DONE);

endmodule

// File: tb/tb_code_loader.sv
// Bench for code_loader: byte-level reference model of the load protocol, randomized frames,
// per-cycle compare of writes and status outputs.
`timescale 1ns/1ps
module tb_code_loader;

    localparam int         CPB  = 16;
    localparam int         CW   = 8;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset, rx;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_nreset, loading, load_error;

    code_loader #(.CLKS_PER_BIT(CPB), .CODE_WORDS(CW), .ADDR_WIDTH(3), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .reset(reset), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_nreset(cpu_nreset), .loading(loading), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: bytes of the current frame after the sync byte.
    typedef struct { int addr; logic [31:0] data; } wr_t;
    bit             m_in_frame = 0, m_ok = 0, m_err = 0;
    byte unsigned   fb[$];
    wr_t            exp_wr[$];
    logic [31:0]    image[CW];
    int             wr_count = 0;
    bit             stable = 0;

    function automatic logic [7:0] sum8(input logic [7:0] q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return 8'(s % 256);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int n, k, s;
        wr_t w;
        if (!m_in_frame) begin
            if (b == SYNC) begin
                m_in_frame = 1; fb.delete(); m_err = 0; m_ok = 0;
            end
        end else begin
            fb.push_back(b);
            n = fb[0];
            k = fb.size();
            if (k == 1) begin
                if (n == 0 || n > CW) begin m_in_frame = 0; m_err = 1; end
            end else if (k <= 1 + 4 * n) begin
                if ((k - 1) % 4 == 0) begin
                    w.addr = (k - 1) / 4 - 1;
                    w.data = {fb[k-1], fb[k-2], fb[k-3], fb[k-4]};
                    exp_wr.push_back(w);
                end
            end else begin
                s = 0;
                for (int i = 1; i <= 4 * n; i++) s += fb[i];
                if (s % 256 == int'(b)) m_ok = 1; else m_err = 1;
                m_in_frame = 0;
            end
        end
    endtask

    task automatic model_frame_err();
        if (m_in_frame) begin m_in_frame = 0; m_err = 1; end
    endtask

    // ---------------- Stimulus helpers ----------------
    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        stable = 0;
        if (good_stop) model_byte(b); else model_frame_err();
        bit_time(good_stop);
        rx = 1'b1;
        repeat (good_stop ? 2 : 40) @(negedge clk);
        stable = 1;
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        stable = 0;
        reset  = 1'b1;
        rx     = 1'b1;
        m_in_frame = 0; m_ok = 0; m_err = 0;
        fb.delete(); exp_wr.delete();
        @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_nreset", cpu_nreset, 0);
        chk("rst_loading", loading, 0);
        chk("rst_load_error", load_error, 0);
        reset = 1'b0;
        @(negedge clk);
        stable = 1;
    endtask

    task automatic clear_image();
        for (int i = 0; i < CW; i++) image[i] = '0;
    endtask

    // ---------------- Compare process ----------------
    always @(negedge clk) begin
        wr_t w;
        if (mem_we === 1'b1) begin
            wr_count++;
            if (exp_wr.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", 32'(mem_addr), w.addr);
                chk("wr_data", mem_wdata, w.data);
            end
            image[mem_addr] = mem_wdata;
        end
        if (stable) begin
            chk("loading", loading, m_in_frame);
            chk("cpu_nreset", cpu_nreset, m_ok);
            chk("load_error", load_error, m_err);
        end
    end

    // ---------------- Main sequence ----------------
    logic [7:0] d1[$], d2[$], q[$];
    int         wc0;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        clear_image();
        do_reset();
        repeat (10) @(negedge clk);

        // Scenario 1: two-word image, correct checksum
        d1 = '{8'h01, 8'h20, 8'h82, 8'hE0, 8'hFD, 8'hFF, 8'hFF, 8'hEA};
        chk("model_csum_s1", sum8(d1), 8'h68);
        q = '{SYNC, 8'h02}; q = {q, d1, sum8(d1)};
        send_bytes(q);
        chk("s1_word0", image[0], 32'hE0822001);
        chk("s1_word1", image[1], 32'hEAFFFFFD);
        chk("s1_cpu_nreset", cpu_nreset, 1);
        chk("s1_loading", loading, 0);
        chk("s1_load_error", load_error, 0);

        // Scenario 2: bad checksum, words still written; then good resend
        clear_image();
        q = '{SYNC, 8'h02}; q = {q, d1, 8'h69};
        send_bytes(q);
        chk("s2_word0", image[0], 32'hE0822001);
        chk("s2_word1", image[1], 32'hEAFFFFFD);
        chk("s2_load_error", load_error, 1);
        chk("s2_cpu_nreset", cpu_nreset, 0);
        q = '{SYNC, 8'h02}; q = {q, d1, sum8(d1)};
        send_bytes(q);
        chk("s2_recover_err", load_error, 0);
        chk("s2_recover_nrst", cpu_nreset, 1);

        // Scenario 3: invalid counts, then a full-depth image
        wc0 = wr_count;
        send_bytes('{SYNC, 8'h00});
        chk("s3_n0_err", load_error, 1);
        send_bytes('{SYNC, 8'h09});
        chk("s3_n9_err", load_error, 1);
        chk("s3_no_writes", wr_count - wc0, 0);
        d2.delete();
        for (int i = 0; i < 32; i++) d2.push_back(8'(i * 37 + 5));
        q = '{SYNC, 8'h08}; q = {q, d2, sum8(d2)};
        send_bytes(q);
        chk("s3_write_count", wr_count - wc0, 8);
        chk("s3_word7", image[7], {d2[31], d2[30], d2[29], d2[28]});
        chk("s3_done", cpu_nreset, 1);

        // Scenario 4: sync in DONE drops CPU reset and starts loading
        send_byte(SYNC, 1'b1);
        chk("s4_nreset", cpu_nreset, 0);
        chk("s4_loading", loading, 1);
        d2 = '{8'h13, 8'h00, 8'hA5, 8'h7F};
        q = '{8'h01}; q = {q, d2, sum8(d2)};
        send_bytes(q);
        chk("s4_word0", image[0], 32'h7FA50013);

        // Scenario 5: short rx glitches are ignored; bad stop bit mid-data errors out
        glitch();
        send_bytes('{SYNC, 8'h01});
        glitch();
        send_bytes('{8'h11, 8'h22});
        glitch();
        send_byte(8'h33, 1'b0);
        chk("s5_err", load_error, 1);
        chk("s5_loading", loading, 0);

        // Scenario 6: reset during the third data byte
        send_bytes('{SYNC, 8'h02, 8'h11, 8'h22});
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        do_reset();
        wc0 = wr_count;
        repeat (300) @(negedge clk);
        chk("s6_no_we_after_reset", wr_count - wc0, 0);

        // Randomized frames
        for (int f = 0; f < 14; f++) begin
            int kind, n, pos;
            logic [7:0] junk;
            kind = $urandom_range(0, 4);
            q.delete();
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                if (junk == SYNC) junk = 8'h5A;
                q.push_back(junk);
            end
            q.push_back(SYNC);
            if (kind == 2) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(CW + 1, 255);
                q.push_back(8'(n));
            end else begin
                n = $urandom_range(1, CW / 2);
                q.push_back(8'(n));
                d2.delete();
                for (int i = 0; i < 4 * n; i++) d2.push_back(8'($urandom));
                q = {q, d2};
                q.push_back(kind == 1 ? 8'(sum8(d2) ^ 8'($urandom_range(1, 255))) : sum8(d2));
            end
            pos = (kind == 3) ? $urandom_range(0, q.size() - 1) : -1;
            for (int i = 0; i < q.size(); i++) begin
                if (kind == 4 && $urandom_range(0, 3) == 0) glitch();
                if (i == pos) begin
                    send_byte(q[i], 1'b0);
                    break;
                end
                send_byte(q[i], 1'b1);
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        chk("pending_writes", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
